// File: rtl/gated_past_buffer.sv
// ============================================================================
// Module   : gated_past_buffer
// Purpose  : Circular history buffer with gated capture; hardware $past(din,tap,gate_en).
//            Optional flush port enabled by GATED_PAST_BUFFER_FLUSH_EN.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module gated_past_buffer #(
  parameter int               WIDTH    = 4,
  parameter int               DEPTH    = 8,
  parameter logic [WIDTH-1:0] INIT_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst_n,
`ifdef GATED_PAST_BUFFER_FLUSH_EN
  input  logic                         flush,
`endif
  input  logic                         gate_en,
  input  logic [WIDTH-1:0]             din,
  input  logic [$clog2(DEPTH+1)-1:0]   tap,
  output logic [WIDTH-1:0]             past_data,
  output logic                         past_valid,
  output logic                         tap_err,
  output logic                         din_stable,
  output logic [$clog2(DEPTH+1)-1:0]   fill_cnt,
  output logic [15:0]                  sample_cnt
);

  localparam int TW = $clog2(DEPTH+1);
  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] c_LAST_PTR = PW'(DEPTH-1);
  localparam logic [PW-1:0] c_DEPTH_P  = PW'(DEPTH);
  localparam logic [TW-1:0] c_DEPTH_T  = TW'(DEPTH);

  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [TW-1:0]    fill_q, fill_d;
  logic [15:0]      cnt_q, cnt_d;
  logic [WIDTH-1:0] mem_q [DEPTH];

  logic             w_flush;
  logic             w_store;
  logic [PW-1:0]    w_tap_p;
  logic [PW-1:0]    w_rd_ptr;

`ifdef GATED_PAST_BUFFER_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  assign w_store = gate_en && !w_flush;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    fill_d   = fill_q;
    cnt_d    = cnt_q;
    if (w_flush) begin
      wr_ptr_d = '0;
      fill_d   = '0;
    end else if (gate_en) begin
      wr_ptr_d = (wr_ptr_q == c_LAST_PTR) ? '0 : wr_ptr_q + PW'(1);
      if (fill_q != c_DEPTH_T) fill_d = fill_q + TW'(1);
      if (cnt_q != 16'hFFFF)   cnt_d  = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      fill_q   <= '0;
      cnt_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      fill_q   <= fill_d;
      cnt_q    <= cnt_d;
    end
  end

  // Storage is intentionally unreset; the fill count masks stale entries.
  always_ff @(posedge clk) begin
    if (w_store) mem_q[wr_ptr_q] <= din;
  end

  // Modular subtraction in pointer width: exact whenever tap is legal, since
  // tap==DEPTH aliases to zero for power-of-two depths and to DEPTH otherwise.
  assign w_tap_p  = tap[PW-1:0];
  assign w_rd_ptr = (wr_ptr_q >= w_tap_p) ? (wr_ptr_q - w_tap_p)
                                          : (wr_ptr_q + c_DEPTH_P - w_tap_p);

  assign tap_err    = (tap == '0) || (tap > c_DEPTH_T);
  assign past_valid = !tap_err && (fill_q >= tap);
  assign past_data  = past_valid ? mem_q[w_rd_ptr] : INIT_VAL;
  assign din_stable = past_valid && (din == past_data);
  assign fill_cnt   = fill_q;
  assign sample_cnt = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_gated_past_buffer.sv
// ============================================================================
// Module   : tb_gated_past_buffer
// Purpose  : Directed, table-driven self-checking bench for gated_past_buffer.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gated_past_buffer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        gate_en = 1'b0;
  logic [3:0]  din = '0;
  logic [3:0]  tap = 4'd1;
  logic [3:0]  past_data;
  logic        past_valid, tap_err, din_stable;
  logic [3:0]  fill_cnt;
  logic [15:0] sample_cnt;
`ifdef GATED_PAST_BUFFER_FLUSH_EN
  logic        flush = 1'b0;
`endif

  int n_applied = 0;
  int n_miss    = 0;

  gated_past_buffer #(.WIDTH(4), .DEPTH(8), .INIT_VAL(4'h0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef GATED_PAST_BUFFER_FLUSH_EN
    .flush      (flush),
`endif
    .gate_en    (gate_en),
    .din        (din),
    .tap        (tap),
    .past_data  (past_data),
    .past_valid (past_valid),
    .tap_err    (tap_err),
    .din_stable (din_stable),
    .fill_cnt   (fill_cnt),
    .sample_cnt (sample_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic        rst;
    logic        gate;
    logic [3:0]  din;
    logic [3:0]  tap;
    logic [3:0]  e_data;
    logic        e_valid;
    logic        e_err;
    logic        e_stable;
    logic [3:0]  e_fill;
    logic [15:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic g, input int d, input int t,
                     input int ed, input logic ev, input logic ee, input logic es,
                     input int ef, input int ec);
    vec_t v;
    v.rst = r; v.gate = g; v.din = 4'(d); v.tap = 4'(t);
    v.e_data = 4'(ed); v.e_valid = ev; v.e_err = ee; v.e_stable = es;
    v.e_fill = 4'(ef); v.e_cnt = 16'(ec);
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input int idx, input logic [15:0] act,
                     input logic [15:0] exp);
    n_applied++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s[%0d]: got %h want %h", name, idx, act, exp);
    end
  endtask

  task automatic chk_all(input int idx, input logic [3:0] ed, input logic ev,
                         input logic ee, input logic es, input logic [3:0] ef,
                         input logic [15:0] ec);
    chk("past_data",  idx, 16'(past_data),  16'(ed));
    chk("past_valid", idx, 16'(past_valid), 16'(ev));
    chk("tap_err",    idx, 16'(tap_err),    16'(ee));
    chk("din_stable", idx, 16'(din_stable), 16'(es));
    chk("fill_cnt",   idx, 16'(fill_cnt),   16'(ef));
    chk("sample_cnt", idx, sample_cnt,      ec);
  endtask

  // Inputs change on the falling edge; the state is stored on the next rising edge.
  task automatic store(input logic [3:0] d);
    gate_en = 1'b1; din = d;
    @(posedge clk); @(negedge clk);
    gate_en = 1'b0;
  endtask

  initial begin
    // Phase 1: fill, tap lookups, gating hold, tap errors
    add(0,1, 1,1,  0,0,0,0, 0,0);
    add(0,1, 2,1,  1,1,0,0, 1,1);
    add(0,1, 3,1,  2,1,0,0, 2,2);
    add(0,0, 0,1,  3,1,0,0, 3,3);
    add(0,0, 0,3,  1,1,0,0, 3,3);
    add(0,0, 0,4,  0,0,0,0, 3,3);
    add(0,0, 3,1,  3,1,0,1, 3,3);
    add(0,1, 5,2,  2,1,0,0, 3,3);
    add(0,0,10,1,  5,1,0,0, 4,4);
    add(0,0, 5,1,  5,1,0,1, 4,4);
    add(0,0,12,1,  5,1,0,0, 4,4);
    add(0,0, 5,1,  5,1,0,1, 4,4);
    add(0,0, 0,4,  1,1,0,0, 4,4);
    add(0,0, 0,0,  0,0,1,0, 4,4);
    add(0,0, 0,9,  0,0,1,0, 4,4);
    add(0,0, 0,15, 0,0,1,0, 4,4);
    add(0,0, 0,5,  0,0,0,0, 4,4);
    // Phase 2: reset, then 12 samples to force wrap-around
    for (int k = 0; k < 12; k++)
      add(k == 0, 1, k, 1, (k > 0) ? k-1 : 0, k > 0, 0, 0, (k > 8) ? 8 : k, k);
    add(0,0, 0,1, 11,1,0,0, 8,12);
    add(0,0, 0,8,  4,1,0,0, 8,12);
    add(0,0, 0,7,  5,1,0,0, 8,12);
    add(0,0, 0,5,  7,1,0,0, 8,12);
    add(0,1, 7,1, 11,1,0,0, 8,12);
    add(0,0, 7,1,  7,1,0,1, 8,13);
    add(0,0, 6,1,  7,1,0,0, 8,13);
    add(0,0, 6,8,  5,1,0,0, 8,13);
    add(0,0, 0,0,  0,0,1,0, 8,13);
    add(0,0, 0,9,  0,0,1,0, 8,13);

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      if (vecs[i].rst) begin
        rst_n = 1'b0; #1; rst_n = 1'b1;
      end
      gate_en = vecs[i].gate;
      din     = vecs[i].din;
      tap     = vecs[i].tap;
      #1;
      chk_all(i, vecs[i].e_data, vecs[i].e_valid, vecs[i].e_err,
              vecs[i].e_stable, vecs[i].e_fill, vecs[i].e_cnt);
      @(posedge clk); @(negedge clk);
    end
    gate_en = 1'b0;

    // Phase 3: asynchronous reset between edges after six samples
    rst_n = 1'b0; #1; rst_n = 1'b1;
    tap = 4'd1; din = 4'd0;
    for (int k = 1; k <= 6; k++) store(4'(k));
    din = 4'd6; #1;
    chk_all(100, 4'd6, 1'b1, 1'b0, 1'b1, 4'd6, 16'd6);
    rst_n = 1'b0; #1;
    chk_all(101, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);
    @(negedge clk);
    rst_n = 1'b1; #1;
    chk_all(102, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd0);

`ifdef GATED_PAST_BUFFER_FLUSH_EN
    // Phase 4: flush beats a simultaneous gate, sample count is kept
    store(4'd1); store(4'd2); store(4'd3);
    din = 4'd0; tap = 4'd1; #1;
    chk_all(200, 4'd3, 1'b1, 1'b0, 1'b0, 4'd3, 16'd3);
    flush = 1'b1; gate_en = 1'b1; din = 4'd9;
    @(posedge clk); @(negedge clk);
    flush = 1'b0; gate_en = 1'b0; #1;
    chk_all(201, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 16'd3);
    store(4'd4);
    din = 4'd0; #1;
    chk_all(202, 4'd4, 1'b1, 1'b0, 1'b0, 4'd1, 16'd4);
    tap = 4'd2; #1;
    chk_all(203, 4'd0, 1'b0, 1'b0, 1'b0, 4'd1, 16'd4);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_applied, n_miss);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/gated_past_buffer.md
Name: gated_past_buffer

Overview:
- Synthesizable circular history buffer with gating; the RTL equivalent of the `$past(sig, N, gate)` checker construct.
- Captures a WIDTH-bit sample on each rising clock edge where the gate is high.
- Exposes the value from N gated samples ago through a runtime-selectable tap, plus valid and stability flags.
- Used by in-design monitors and self-checking datapaths that need cycle-accurate history without simulation-only system functions.

Parameters:
- WIDTH, 4: sample data width in bits, >= 1.
- DEPTH, 8: number of gated samples retained, >= 2, any integer (not restricted to a power of two).
- INIT_VAL, 0: WIDTH-bit value returned when the requested history does not exist.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- gate_en  input  1  sample gate; a sample is stored only at edges where gate_en=1.
- din  input  WIDTH  signal being tracked.
- tap  input  $clog2(DEPTH+1)  history distance N; legal range 1..DEPTH.
- past_data  output  WIDTH  value of din from the tap-th most recent gated sample.
- past_valid  output  1  1 when tap is legal and at least tap samples have been stored.
- tap_err  output  1  1 when tap==0 or tap>DEPTH.
- din_stable  output  1  past_valid && (din == past_data).
- fill_cnt  output  $clog2(DEPTH+1)  number of stored samples, saturating at DEPTH.
- sample_cnt  output  16  total gated samples taken, saturating at 16'hFFFF.

Behaviour:
- Reset (rst_n=0, asynchronous):
  - wr_ptr=0, fill_cnt=0, sample_cnt=0.
  - Storage array is NOT reset, so its contents are don't-care.
  - Outputs settle to past_valid=0 and past_data=INIT_VAL; din_stable=0.
  - Reset asserted mid-operation discards all history immediately; there is no partial retention.
- Rising edge with gate_en=1:
  - mem[wr_ptr] <= din.
  - wr_ptr <= (wr_ptr==DEPTH-1) ? 0 : wr_ptr+1. The wrap must be explicit, not natural binary overflow.
  - fill_cnt increments until it reaches DEPTH, then holds.
  - sample_cnt increments until it reaches 16'hFFFF, then holds.
- Rising edge with gate_en=0:
  - All state holds; the history does not advance, matching `$past` gating semantics.
- Read path (combinational from registered state; zero-cycle latency relative to state):
  - rd_idx = (wr_ptr - tap) mod DEPTH, computed without negative wrap error. Suggested form: wr_ptr >= tap ? wr_ptr-tap : wr_ptr+DEPTH-tap.
  - tap_err = (tap==0) || (tap>DEPTH).
  - past_valid = !tap_err && (fill_cnt >= tap).
  - past_data = past_valid ? mem[rd_idx] : INIT_VAL.
- Timing semantics:
  - At the edge that stores sample k, the write commits after that edge.
  - Right after the edge, tap=1 returns sample k.
  - At the sampling edge itself, past_data reflects the pre-edge state, i.e. the previous gated sample. This is equivalent to `$past(din,tap,gate_en)` evaluated at that edge.
- Simultaneous gate_en=1 and a read of the slot being overwritten: the reader sees the old value until the edge; no bypass path exists.
- Wrap-around: after more than DEPTH samples, the oldest entry is overwritten. tap=DEPTH always addresses the oldest retained sample.
- Changing tap takes effect combinationally; it has no effect on state.

Optional Feature:
- Macro: GATED_PAST_BUFFER_FLUSH_EN.
- When defined:
  - Adds input port flush (1 bit).
  - A rising edge with flush=1 sets fill_cnt=0 and wr_ptr=0, and leaves sample_cnt unchanged.
  - flush has priority over gate_en in the same cycle; that cycle's din is not stored.
  - past_valid drops to 0 on the following state.
- When undefined: no flush port, and history is cleared only by rst_n.

Test Plan:
- Reset check: hold rst_n=0, then release -> past_valid=0, past_data=INIT_VAL=0, fill_cnt=0, sample_cnt=0, tap_err=0 with tap=1.
- Gated fill, DEPTH=8: with gate_en=1, drive din=1,2,3 on three edges, then tap=1 and tap=3 -> past_data=3 and past_data=1 respectively, both past_valid=1; tap=4 -> past_valid=0, past_data=0.
- Gating hold: after storing 5, hold gate_en=0 for 4 edges while din toggles -> tap=1 still returns 5, and fill_cnt and sample_cnt are unchanged.
- Wrap: store din=0..11 with gate_en=1 every edge -> fill_cnt=8, sample_cnt=12, tap=1 gives 11, tap=8 gives 4.
- Tap error and stability: tap=0 and tap=9 -> tap_err=1, past_valid=0; tap=1 with past_data=7 and din=7 -> din_stable=1; din=6 -> din_stable=0.
- Async reset mid-run: assert rst_n=0 between edges after 6 samples -> fill_cnt=0 and past_valid=0 immediately without a clock; with the flush macro defined, flush=1 together with gate_en=1 -> fill_cnt=0 and the din of that cycle is not stored.
